// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared constants and state encoding for the oversampled
//               UART receiver and its baud-tick prescaler.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Ticks per bit period and the tick-counter value at the bit mid-point
  localparam int unsigned OVERSAMPLE        = 16;
  localparam logic [3:0]  MID_TICK          = 4'd7;
  localparam logic [3:0]  LAST_TICK         = 4'(OVERSAMPLE - 1);

  // 54 clocks per tick at 100 MHz gives 115 740 baud
  localparam int unsigned CLKS_PER_TICK_DEF = 54;

  // Receiver state encoding
  localparam logic [2:0] c_ST_IDLE      = 3'd0;
  localparam logic [2:0] c_ST_START     = 3'd1;
  localparam logic [2:0] c_ST_DATA      = 3'd2;
  localparam logic [2:0] c_ST_STOP      = 3'd3;
  localparam logic [2:0] c_ST_WAIT_IDLE = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE      = c_ST_IDLE,
    ST_START     = c_ST_START,
    ST_DATA      = c_ST_DATA,
    ST_STOP      = c_ST_STOP,
    ST_WAIT_IDLE = c_ST_WAIT_IDLE
  } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx_oversampled_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_oversampled_if
// Description : Serial line input and received-byte handshake of the
//               oversampled UART receiver.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_oversampled_if;

  logic       uart_txd_in;   // serial line, idle high
  logic       recived_sig;   // one-cycle strobe: good byte received
  logic [7:0] recived_data;  // last good byte, held
  logic       frame_err;     // one-cycle strobe: stop bit sampled low
  logic       rx_busy;       // receiver not idle

  // Line driver / byte consumer side
  modport master (
    output uart_txd_in,
    input  recived_sig,
    input  recived_data,
    input  frame_err,
    input  rx_busy
  );

  // Receiver side
  modport slave (
    input  uart_txd_in,
    output recived_sig,
    output recived_data,
    output frame_err,
    output rx_busy
  );

endinterface
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_tick
// Description : Prescaler counting 0..CLKS_PER_TICK-1 with a synchronous
//               clear; emits a one-cycle tick on the terminal count.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_TICK = CLKS_PER_TICK_DEF
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic i_clear,
  output logic      o_tick
);

  localparam int unsigned        c_CNT_W = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(CLKS_PER_TICK - 1);

  logic [c_CNT_W-1:0] r_cnt;

  // Wrap at the terminal count; clear holds the count at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear || (r_cnt == c_LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // A cleared prescaler never ticks, so the first tick lands a full period later
  assign o_tick = !i_clear && (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_rx_oversampled.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_oversampled
// Description : 8N1 UART receiver, 16x oversampled, mid-bit sampling,
//               start-glitch rejection and framing-error detection.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_oversampled
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_TICK = CLKS_PER_TICK_DEF
) (
  input  wire logic             clk100mhz,
  input  wire logic             cpu_resetn,
  uart_rx_oversampled_if.slave  bus
);

  logic       r_sync1;
  logic       r_rxs;
  rx_state_t  r_state;
  rx_state_t  w_state_next;
  logic [3:0] r_tick_cnt;
  logic [2:0] r_bit_idx;
  logic [7:0] r_shift;
  logic [7:0] r_data;
  logic       r_sig;
  logic       r_ferr;
  logic       r_busy;

  logic       w_tick;
  logic       w_mid;
  logic       w_bit_end;
  logic       w_shift_en;
  logic       w_good;
  logic       w_bad;

  // Prescaler only runs while a frame is in progress
  uart_baud_tick #(
    .CLKS_PER_TICK (CLKS_PER_TICK)
  ) u_baud (
    .clk     (clk100mhz),
    .rst_n   (cpu_resetn),
    .i_clear (r_state == ST_IDLE),
    .o_tick  (w_tick)
  );

  assign w_mid     = w_tick && (r_tick_cnt == MID_TICK);
  assign w_bit_end = w_tick && (r_tick_cnt == LAST_TICK);

  // Two-flop synchroniser; resets to the idle-high line level
  always_ff @(posedge clk100mhz or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      r_sync1 <= 1'b1;
      r_rxs   <= 1'b1;
    end else begin
      r_sync1 <= bus.uart_txd_in;
      r_rxs   <= r_sync1;
    end
  end

  // State register
  always_ff @(posedge clk100mhz or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and per-cycle actions: start qualification, data shift, stop check
  always_comb begin
    w_state_next = r_state;
    w_shift_en   = 1'b0;
    w_good       = 1'b0;
    w_bad        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!r_rxs) begin
          w_state_next = ST_START;
        end
      end
      ST_START: begin
        if (w_mid) begin
          w_state_next = r_rxs ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_bit_end) begin
          w_shift_en = 1'b1;
          if (r_bit_idx == 3'd7) begin
            w_state_next = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (w_bit_end) begin
          if (r_rxs) begin
            w_good       = 1'b1;
            w_state_next = ST_IDLE;
          end else begin
            w_bad        = 1'b1;
            w_state_next = ST_WAIT_IDLE;
          end
        end
      end
      ST_WAIT_IDLE: begin
        if (r_rxs) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Tick and bit counters; the tick count restarts on every state change
  always_ff @(posedge clk100mhz or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      r_tick_cnt <= 4'd0;
      r_bit_idx  <= 3'd0;
    end else begin
      if (w_state_next != r_state) begin
        r_tick_cnt <= 4'd0;
      end else if (w_tick) begin
        r_tick_cnt <= r_tick_cnt + 4'd1;
      end
      if (r_state == ST_START) begin
        r_bit_idx <= 3'd0;
      end else if (w_shift_en) begin
        r_bit_idx <= r_bit_idx + 3'd1;
      end
    end
  end

  // Shift register fills from the MSB side so the first (LSB) bit ends at bit 0
  always_ff @(posedge clk100mhz or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      r_shift <= 8'h00;
    end else if (w_shift_en) begin
      r_shift <= {r_rxs, r_shift[7:1]};
    end
  end

  // Output registers: strobes are mutually exclusive, data held across bad frames
  always_ff @(posedge clk100mhz or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      r_data <= 8'h00;
      r_sig  <= 1'b0;
      r_ferr <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_sig  <= w_good;
      r_ferr <= w_bad;
      r_busy <= (w_state_next != ST_IDLE);
      if (w_good) begin
        r_data <= r_shift;
      end
    end
  end

  assign bus.recived_sig  = r_sig;
  assign bus.recived_data = r_data;
  assign bus.frame_err    = r_ferr;
  assign bus.rx_busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_oversampled.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_oversampled
// Description : Self-checking bench for uart_rx_oversampled: directed frames,
//               glitch, framing error, reset and baud-skew cases plus a
//               randomized frame, checked every cycle against a timestamp model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_rx_oversampled;

  localparam int CPT = 54;
  localparam int BIT = 16 * CPT;   // clocks per bit
  localparam int MID = 8 * CPT;    // start mid-point offset from detection

  logic clk100mhz  = 1'b0;
  logic cpu_resetn = 1'b1;

  uart_rx_oversampled_if bus ();

  uart_rx_oversampled #(
    .CLKS_PER_TICK (CPT)
  ) dut (
    .clk100mhz  (clk100mhz),
    .cpu_resetn (cpu_resetn),
    .bus        (bus)
  );

  always #5 clk100mhz = ~clk100mhz;

  int cyc = 0;
  always @(posedge clk100mhz) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {M_IDLE, M_FRAME, M_WAIT} mmode_t;
  mmode_t     m_mode = M_IDLE;
  int         m_t0   = 0;
  logic [7:0] m_byte = 8'h00;
  logic       p_d1   = 1'b1;
  logic       p_d2   = 1'b1;
  logic       e_sig  = 1'b0;
  logic       e_ferr = 1'b0;
  logic       e_busy = 1'b0;
  logic [7:0] e_data = 8'h00;

  int         sig_cyc[$];
  logic [7:0] sig_dat[$];
  int         ferr_cnt = 0;

  // Compare DUT outputs with the model, then advance the model by one cycle
  always @(negedge clk100mhz) begin : compare
    logic rxs;
    int   d;
    int   k;
    if (!cpu_resetn) begin
      m_mode = M_IDLE;
      e_sig  = 1'b0;
      e_ferr = 1'b0;
      e_busy = 1'b0;
      e_data = 8'h00;
      p_d1   = 1'b1;
      p_d2   = 1'b1;
    end
    check("recived_sig",  32'(bus.recived_sig),  32'(e_sig));
    check("frame_err",    32'(bus.frame_err),    32'(e_ferr));
    check("rx_busy",      32'(bus.rx_busy),      32'(e_busy));
    check("recived_data", 32'(bus.recived_data), 32'(e_data));
    if (bus.recived_sig === 1'b1) begin
      sig_cyc.push_back(cyc);
      sig_dat.push_back(bus.recived_data);
    end
    if (bus.frame_err === 1'b1) ferr_cnt++;
    if (cpu_resetn) begin
      // Line level seen by the receiver logic lags the pin by two clocks
      rxs    = p_d2;
      p_d2   = p_d1;
      p_d1   = bus.uart_txd_in;
      e_sig  = 1'b0;
      e_ferr = 1'b0;
      case (m_mode)
        M_IDLE: begin
          if (!rxs) begin
            m_mode = M_FRAME;
            m_t0   = cyc;
            m_byte = 8'h00;
          end
        end
        M_FRAME: begin
          d = cyc - m_t0;
          if (d == MID) begin
            if (rxs) m_mode = M_IDLE;
          end else if (d > MID && ((d - MID) % BIT) == 0) begin
            k = (d - MID) / BIT;
            if (k <= 8) begin
              m_byte[k-1] = rxs;
            end else if (rxs) begin
              e_data = m_byte;
              e_sig  = 1'b1;
              m_mode = M_IDLE;
            end else begin
              e_ferr = 1'b1;
              m_mode = M_WAIT;
            end
          end
        end
        default: begin
          if (rxs) m_mode = M_IDLE;
        end
      endcase
      e_busy = (m_mode != M_IDLE);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk100mhz);
      #2;
    end
  endtask

  task automatic clear_log();
    sig_cyc.delete();
    sig_dat.delete();
    ferr_cnt = 0;
  endtask

  task automatic send_frame(input logic [7:0] b, input int per, input logic stop, output int s);
    s = cyc;
    bus.uart_txd_in = 1'b0;
    step(per);
    for (int i = 0; i < 8; i++) begin
      bus.uart_txd_in = b[i];
      step(per);
    end
    bus.uart_txd_in = stop;
    step(per);
  endtask

  initial begin
    int         s;
    int         s2;
    logic [7:0] rb;
    int         rp;
    logic       rs;

    bus.uart_txd_in = 1'b1;
    #1 cpu_resetn = 1'b0;
    step(3);
    check("reset_sig",  32'(bus.recived_sig),  32'd0);
    check("reset_data", 32'(bus.recived_data), 32'h00);
    check("reset_ferr", 32'(bus.frame_err),    32'd0);
    check("reset_busy", 32'(bus.rx_busy),      32'd0);
    cpu_resetn = 1'b1;
    step($urandom_range(20, 60));

    // Single good frame
    clear_log();
    send_frame(8'h22, BIT, 1'b1, s);
    step(20);
    check("f22_count", 32'(sig_cyc.size()), 32'd1);
    if (sig_cyc.size() > 0) begin
      check("f22_time", 32'(sig_cyc[0]), 32'(s + 2 + 8209));
      check("f22_data", 32'(sig_dat[0]), 32'h22);
    end
    check("f22_ferr", 32'(ferr_cnt), 32'd0);

    // Start glitch
    clear_log();
    s = cyc;
    bus.uart_txd_in = 1'b0;
    step(200);
    bus.uart_txd_in = 1'b1;
    step(100);
    check("glitch_busy_hi", 32'(bus.rx_busy), 32'd1);
    step(140);
    check("glitch_busy_lo", 32'(bus.rx_busy), 32'd0);
    check("glitch_sig",  32'(sig_cyc.size()), 32'd0);
    check("glitch_ferr", 32'(ferr_cnt), 32'd0);
    step($urandom_range(1, 40));
    send_frame(8'hA5, BIT, 1'b1, s);
    step(20);
    check("fA5_count", 32'(sig_cyc.size()), 32'd1);
    if (sig_cyc.size() > 0) check("fA5_data", 32'(sig_dat[0]), 32'hA5);

    // Framing error followed by a held break
    clear_log();
    send_frame(8'h3C, BIT, 1'b0, s);
    step(2000);
    check("ferr_count", 32'(ferr_cnt), 32'd1);
    check("ferr_sig",   32'(sig_cyc.size()), 32'd0);
    check("ferr_data",  32'(bus.recived_data), 32'hA5);
    check("ferr_busy",  32'(bus.rx_busy), 32'd1);
    bus.uart_txd_in = 1'b1;
    step(5);
    check("ferr_busy_lo", 32'(bus.rx_busy), 32'd0);
    step($urandom_range(1, 40));

    // Back-to-back frames
    clear_log();
    send_frame(8'h55, BIT, 1'b1, s);
    send_frame(8'hA3, BIT, 1'b1, s2);
    step(20);
    check("b2b_count", 32'(sig_cyc.size()), 32'd2);
    if (sig_cyc.size() > 1) begin
      check("b2b_time0", 32'(sig_cyc[0]), 32'(s + 2 + 8209));
      check("b2b_gap",   32'(sig_cyc[1] - sig_cyc[0]), 32'd8640);
      check("b2b_data0", 32'(sig_dat[0]), 32'h55);
      check("b2b_data1", 32'(sig_dat[1]), 32'hA3);
    end

    // Reset during data bit 4
    clear_log();
    rb = 8'h6A;
    bus.uart_txd_in = 1'b0;
    step(BIT);
    for (int i = 0; i < 4; i++) begin
      bus.uart_txd_in = rb[i];
      step(BIT);
    end
    bus.uart_txd_in = rb[4];
    step(400);
    check("rst_busy_before", 32'(bus.rx_busy), 32'd1);
    cpu_resetn = 1'b0;
    #1;
    check("rst_data", 32'(bus.recived_data), 32'h00);
    check("rst_sig",  32'(bus.recived_sig),  32'd0);
    check("rst_ferr", 32'(bus.frame_err),    32'd0);
    check("rst_busy", 32'(bus.rx_busy),      32'd0);
    bus.uart_txd_in = 1'b1;
    step(20);
    cpu_resetn = 1'b1;
    step(50);
    send_frame(8'h81, BIT, 1'b1, s);
    step(20);
    check("f81_count", 32'(sig_cyc.size()), 32'd1);
    if (sig_cyc.size() > 0) check("f81_data", 32'(sig_dat[0]), 32'h81);

    // Baud tolerance
    clear_log();
    send_frame(8'hF0, 847, 1'b1, s);
    step($urandom_range(5, 30));
    send_frame(8'h0F, 881, 1'b1, s2);
    step(20);
    check("baud_count", 32'(sig_cyc.size()), 32'd2);
    if (sig_cyc.size() > 1) begin
      check("baud_data0", 32'(sig_dat[0]), 32'hF0);
      check("baud_data1", 32'(sig_dat[1]), 32'h0F);
    end
    check("baud_ferr", 32'(ferr_cnt), 32'd0);

    // Randomized frame: random byte, skewed bit period, occasional bad stop
    clear_log();
    rb = 8'($urandom);
    rp = $urandom_range(850, 878);
    rs = ($urandom_range(0, 3) != 0);
    send_frame(rb, rp, rs, s);
    if (!rs) begin
      step($urandom_range(50, 300));
      bus.uart_txd_in = 1'b1;
    end
    step(30);
    check("rand_count", 32'(sig_cyc.size()), 32'(rs));
    check("rand_ferr",  32'(ferr_cnt), 32'(!rs));
    if (rs && sig_cyc.size() > 0) check("rand_data", 32'(sig_dat[0]), 32'(rb));

    step(10);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_oversampled.md
# uart_rx_oversampled

Standalone 8N1 UART receiver with 16x oversampling, mid-bit sampling, start-glitch rejection and framing-error detection. It deserialises the line driven by the `uart_controller` transmitter (`uart_rxd_out`), so the pair can be looped back on the board or in simulation. Received bytes are presented as a one-cycle strobe plus a held data byte, using the same handshake style as the controller's `recived_sig` / `recived_data`.

## Interface

Parameters:
- `CLKS_PER_TICK`, default 54. Number of `clk100mhz` cycles per oversample tick.
  - One bit is 16 ticks = 864 cycles, giving 115 740 baud (0.47 % from 115 200).
  - Legal range is 2 and up.

Ports:
- `clk100mhz`, in, 1. The single system clock. All state changes on its rising edge.
- `cpu_resetn`, in, 1. Reset is asynchronous and active-low.
- `uart_txd_in`, in, 1. Asynchronous serial input, idle high.
- `recived_sig`, out, 1. One-cycle strobe: a valid byte has been received.
- `recived_data`, out, 8. Last good byte. Holds its value until the next good frame.
- `frame_err`, out, 1. One-cycle strobe: the stop bit was sampled low.
- `rx_busy`, out, 1. High in every state except IDLE.

## Operation

- **Input synchroniser:** 2-flop synchroniser on `uart_txd_in`, both flops reset to 1. All logic uses the synchronised value `rxs`.
- **Prescaler:**
  - Counts 0..`CLKS_PER_TICK`-1 and emits `tick` on the terminal count.
  - Cleared to 0 in IDLE.
  - Free-running in all other states.
- **Tick counter:** 4 bits, counts ticks within the current bit. Cleared whenever the state changes.
- **Bit index:** 3 bits. The shift register fills from the MSB side, so the LSB is received first.
- **States:**
  - IDLE:
    - When `rxs`=0, go to START and clear the prescaler and tick counter.
  - START:
    - Wait for the 8th tick (the mid-point of the start bit).
    - If `rxs`=0 at that tick, go to DATA with bit index 0.
    - If `rxs`=1, the low pulse was a glitch: go to IDLE and emit no strobes.
  - DATA:
    - On every 16th tick, shift `rxs` into the shift register and increment the bit index.
    - After bit 7 is sampled, go to STOP.
  - STOP:
    - On the 16th tick, sample `rxs`.
    - If `rxs`=1: load `recived_data` from the shift register, pulse `recived_sig`, go to IDLE.
    - If `rxs`=0: pulse `frame_err`, leave `recived_data` unchanged, go to WAIT_IDLE.
  - WAIT_IDLE:
    - Stay here while `rxs`=0. This prevents a break condition from re-triggering a receive.
    - Go to IDLE on the first cycle with `rxs`=1.
- **Strobe exclusivity:** `recived_sig` and `frame_err` are never high in the same cycle.
- **Reset values (asynchronous, any time including mid-frame):**
  - State = IDLE; prescaler, tick counter and bit index = 0.
  - Shift register = 8'h00; synchroniser flops = 1.
  - `recived_data` = 8'h00; `recived_sig` = 0; `frame_err` = 0; `rx_busy` = 0.
  - Any partial frame is discarded.

## Timing

Let t be the first cycle in which `rxs`=0 while the block is in IDLE. The pin falling edge is 2 cycles earlier, because of the synchroniser.

- **Sample instants:**
  - Start mid-point is sampled at t+8·`CLKS_PER_TICK` (t+432 at the default).
  - Data bit i (i = 0..7) is sampled at t+432+(i+1)·864.
  - The stop bit is sampled at t+432+9·864 = t+8208.
- **Strobe timing:**
  - `recived_sig` or `frame_err` is high for exactly one cycle, at t+8209. `recived_data` is valid from that same cycle.
  - The block is back in IDLE at t+8209. A start bit that immediately follows the stop bit is therefore detected, so back-to-back frames need no idle gap.
- **Baud tolerance:** a sender bit period of 864 ± 2 % (847..881 cycles) must be received without error.
- **`rx_busy` timing:** `rx_busy` is registered from the state. It rises at t+1 and falls at t+8209 (or when WAIT_IDLE exits).

## Structure

- **Shared package `uart_pkg`:**
  - Constant `OVERSAMPLE` = 16.
  - Constant `MID_TICK` = 7 (the tick counter value at the 8th tick).
  - Default `CLKS_PER_TICK` = 54.
  - State encoding: IDLE, START, DATA, STOP, WAIT_IDLE, as 3-bit localparams.
- **Sub-module `uart_baud_tick`:**
  - Parameterised prescaler with a synchronous clear, producing a one-cycle `tick`.
  - The controller's transmitter reuses it at a 16x rate.
- **Top level:** the synchroniser, FSM, counters and output registers stay in `uart_rx_oversampled`.

## Test plan

- **Single good frame:** drive 0x22 as 8N1 at 864 cycles/bit, then hold idle.
  - Exactly one `recived_sig` pulse, at pin-start + 2 + 8209 cycles.
  - `recived_data` = 0x22; `frame_err` never high.
- **Start glitch:** pulse the line low for 200 cycles, then hold it high.
  - No strobe of either kind.
  - `rx_busy` drops back to 0 after about 432 cycles.
  - A following frame 0xA5 is received correctly.
- **Framing error:** send 0x3C with the stop bit low, then keep the line low for 2000 cycles.
  - One `frame_err` pulse and no `recived_sig`.
  - `recived_data` keeps its previous value.
  - `rx_busy` stays high until the line returns high.
- **Back-to-back frames:** send 0x55 then 0xA3 with no idle bits between them.
  - Two `recived_sig` pulses, 8640 cycles apart, with data 0x55 then 0xA3.
- **Reset mid-frame:** assert `cpu_resetn`=0 during data bit 4 of a frame.
  - All outputs take their reset values immediately.
  - After release, a fresh 0x81 is received correctly.
- **Baud tolerance:** send 0xF0 at 847 cycles/bit, then 0x0F at 881 cycles/bit.
  - Both bytes are received correctly with no `frame_err`.
